// File: rtl/bp_table_sequencer_if.sv
// Fetch-side lookup/prediction and commit-side update handshakes of the predictor sequencer.
// master = fetch/commit logic, slave = sequencer.
interface bp_table_sequencer_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken,
        input  lookup_ready, pred_valid, pred_taken, upd_ready
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken,
        output lookup_ready, pred_valid, pred_taken, upd_ready
    );
endinterface

// File: rtl/bp_table_sequencer.sv
// Serialises fetch lookups and buffered commit updates onto single-port LHT/PHT SRAMs.
// Lookup: prediction 2 cycles after accept; update: 3 cycles; commit stalls only when the update FIFO is full.
module bp_table_sequencer #(
    parameter int LHT_DEPTH  = 256,
    parameter int HIST_LEN   = 4,
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_MAX = 4,
    localparam int IW        = $clog2(LHT_DEPTH),
    localparam int PHT_DEPTH = 2 ** HIST_LEN
) (
    input  logic                clk,
    input  logic                rst,
    bp_table_sequencer_if.slave io_bus,
    output logic                o_lht_csb,
    output logic                o_lht_web,
    output logic [IW-1:0]       o_lht_addr,
    output logic [HIST_LEN-1:0] o_lht_din,
    input  logic [HIST_LEN-1:0] i_lht_dout,
    output logic                o_pht_csb,
    output logic                o_pht_web,
    output logic [HIST_LEN-1:0] o_pht_addr,
    output logic [1:0]          o_pht_din,
    input  logic [1:0]          i_pht_dout
);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = $clog2(UPD_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LK_PHT  = 3'd1;
    localparam logic [2:0] S_LK_RESP = 3'd2;
    localparam logic [2:0] S_UP_HIST = 3'd3;
    localparam logic [2:0] S_UP_CTR  = 3'd4;

    logic [2:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic                 r_taken;
    logic                 r_lht_v;
    logic [HIST_LEN-1:0]  r_hist;
    logic [LHT_DEPTH-1:0] r_lht_vld;
    logic [PHT_DEPTH-1:0] r_pht_vld;
    logic [IW-1:0]        r_fifo_idx [UPD_DEPTH];
    logic [UPD_DEPTH-1:0] r_fifo_tk;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_cnt;
    logic [SW-1:0]        r_starve;

    logic                w_empty, w_full, w_idle, w_push;
    logic                w_grant_upd, w_grant_lk;
    logic [IW-1:0]       w_lk_idx, w_upd_idx, w_head_idx;
    logic                w_head_tk, w_up_lv;
    logic [HIST_LEN-1:0] w_new_hist;
    logic [1:0]          w_ctr;
    logic                w_unused;

    assign w_unused   = ^{io_bus.lookup_pc[31:IW+2], io_bus.lookup_pc[1:0],
                          io_bus.upd_pc[31:IW+2], io_bus.upd_pc[1:0]};
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CW'(UPD_DEPTH));
    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_lk_idx   = io_bus.lookup_pc[IW+1:2];
    assign w_upd_idx  = io_bus.upd_pc[IW+1:2];
    assign w_head_idx = r_fifo_idx[r_rd_ptr];
    assign w_head_tk  = r_fifo_tk[r_rd_ptr];

    // A pending update wins when the FIFO is full, lookups have starved it, or fetch is quiet.
    assign w_grant_upd = w_idle && !w_empty &&
                         (w_full || (r_starve == SW'(STARVE_MAX)) || !io_bus.lookup_valid);
    assign w_grant_lk  = w_idle && io_bus.lookup_valid && !w_grant_upd;
    assign w_push      = io_bus.upd_valid && !w_full && !rst;

    assign w_up_lv    = r_lht_vld[r_idx];
    assign w_new_hist = w_up_lv ? {i_lht_dout[HIST_LEN-2:0], r_taken}
                                : {{(HIST_LEN-1){1'b0}}, r_taken};

    always_comb begin
        w_ctr = i_pht_dout;
        if (!r_pht_vld[r_hist])
            w_ctr = r_taken ? 2'b10 : 2'b01;
        else if (r_taken && (i_pht_dout != 2'b11))
            w_ctr = i_pht_dout + 2'd1;
        else if (!r_taken && (i_pht_dout != 2'b00))
            w_ctr = i_pht_dout - 2'd1;
    end

    assign io_bus.lookup_ready = w_grant_lk;
    assign io_bus.upd_ready    = !rst && !w_full;
    assign io_bus.pred_valid   = !rst && (r_state == S_LK_RESP);
    assign io_bus.pred_taken   = io_bus.pred_valid && r_lht_v && r_pht_vld[r_hist] && i_pht_dout[1];

    always_comb begin
        o_lht_csb  = 1'b1;
        o_lht_web  = 1'b1;
        o_lht_addr = '0;
        o_lht_din  = '0;
        o_pht_csb  = 1'b1;
        o_pht_web  = 1'b1;
        o_pht_addr = '0;
        o_pht_din  = '0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_lk) begin
                        o_lht_csb  = 1'b0;
                        o_lht_addr = w_lk_idx;
                    end else if (w_grant_upd) begin
                        o_lht_csb  = 1'b0;
                        o_lht_addr = w_head_idx;
                    end
                end
                S_LK_PHT: begin
                    o_pht_csb  = 1'b0;
                    o_pht_addr = i_lht_dout;
                end
                S_UP_HIST: begin
                    o_lht_csb  = 1'b0;
                    o_lht_web  = 1'b0;
                    o_lht_addr = r_idx;
                    o_lht_din  = w_new_hist;
                    if (w_up_lv) begin
                        o_pht_csb  = 1'b0;
                        o_pht_addr = i_lht_dout;
                    end
                end
                S_UP_CTR: begin
                    if (r_lht_v) begin
                        o_pht_csb  = 1'b0;
                        o_pht_web  = 1'b0;
                        o_pht_addr = r_hist;
                        o_pht_din  = w_ctr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_taken   <= 1'b0;
            r_lht_v   <= 1'b0;
            r_hist    <= '0;
            r_lht_vld <= '0;
            r_pht_vld <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_starve  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_lk) begin
                        r_idx   <= w_lk_idx;
                        r_state <= S_LK_PHT;
                    end else if (w_grant_upd) begin
                        r_idx   <= w_head_idx;
                        r_taken <= w_head_tk;
                        r_state <= S_UP_HIST;
                    end
                end
                S_LK_PHT: begin
                    r_lht_v <= r_lht_vld[r_idx];
                    r_hist  <= i_lht_dout;
                    r_state <= S_LK_RESP;
                end
                S_UP_HIST: begin
                    r_lht_vld[r_idx] <= 1'b1;
                    r_lht_v          <= w_up_lv;
                    r_hist           <= i_lht_dout;
                    r_state          <= S_UP_CTR;
                end
                S_UP_CTR: begin
                    if (r_lht_v)
                        r_pht_vld[r_hist] <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_grant_upd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_grant_upd);

            if (w_grant_upd || w_empty)
                r_starve <= '0;
            else if (w_grant_lk)
                r_starve <= r_starve + 1'b1;
        end
    end

    // Payload storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= w_upd_idx;
            r_fifo_tk[r_wr_ptr]  <= io_bus.upd_taken;
        end
    end
endmodule
